scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable and an auto-scan mode. In direct mode it decodes a select input into a registered one-hot output. In scan mode it steps the active output through all 2^N lines at a programmable dwell rate and flags each wrap. It replaces the combinational 3-to-8 decoder wherever a clocked or time-multiplexed select is needed, for example digit scanning or row strobing.

---
 rtl/scan_decoder.sv | 81 ++++++++
 tb/tb_scan_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, direct-decode and auto-scan modes.
// One clock from sampled inputs to D/idx/wrap; no backpressure, inputs are sampled every clock.
module scan_decoder #(
  parameter int N     = 3,
  parameter int DIV_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       x,
  input  logic [DIV_W-1:0]   dwell,
  output logic [(1<<N)-1:0]  D,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int W = 1 << N;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     d_q, d_d;
  logic [N-1:0]     idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] pre_q, pre_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      pre_q   <= pre_d;
    end
  end

  // Priority: en, then mode, then scan entry, then the dwell-driven advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      pre_d   = '0;
    end else if (!mode) begin
      state_d = DIRECT;
      idx_d   = x;
      pre_d   = '0;
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      idx_d   = '0;
      pre_d   = '0;
    end else if (pre_q >= dwell) begin
      pre_d  = '0;
      idx_d  = idx_q + N'(1);
      wrap_d = (idx_q == {N{1'b1}});
    end else begin
      pre_d = pre_q + DIV_W'(1);
    end
    d_d = (state_d == IDLE) ? '0 : (ONE << idx_d);
  end

  assign D    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (N=3, DIV_W=4): vector table, corner sequences, random run vs model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic [2:0] x;
  logic [3:0] dwell;
  logic [7:0] D;
  logic [2:0] idx;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: which line is lit and how long it has been lit.
  int m_st;    // 0 idle, 1 direct, 2 scan
  int m_line;
  int m_held;
  int m_wrap;

  typedef struct {
    logic       en;
    logic       mode;
    logic [2:0] x;
    logic [3:0] dwell;
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  vec_t tbl[18];

  scan_decoder #(.N(3), .DIV_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .x(x),
    .dwell(dwell), .D(D), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_line = 0; m_held = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    m_wrap = 0;
    if (!en) begin
      m_st = 0; m_line = 0; m_held = 0;
    end else if (!mode) begin
      m_st = 1; m_line = int'(x); m_held = 0;
    end else if (m_st != 2) begin
      m_st = 2; m_line = 0; m_held = 0;
    end else if (m_held >= int'(dwell)) begin
      m_held = 0;
      m_line = (m_line + 1) % 8;
      m_wrap = (m_line == 0) ? 1 : 0;
    end else begin
      m_held = m_held + 1;
    end
  endtask

  function automatic int model_d();
    return (m_st == 0) ? 0 : (1 << m_line);
  endfunction

  // One clock: model sees the same inputs the DUT samples; outputs read 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".D"},    32'(D),    32'(model_d()));
    check({tag, ".idx"},  32'(idx),  32'(m_line));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  task automatic check_invariant();
    check("onehot", 32'((D == 8'h0) || $onehot(D)), 32'd1);
    if (D != 8'h0) check("D[idx]", 32'(D[idx]), 32'd1);
  endtask

  initial begin
    int n;
    int t_entry;
    int t_w1;
    int t_w2;

    tbl[0]  = '{1'b1, 1'b0, 3'd5, 4'd0, 8'h20, 3'd5, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'd2, 4'd0, 8'h04, 3'd2, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'd7, 4'd0, 8'h01, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3'd7, 4'd0, 8'h02, 3'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 3'd7, 4'd2, 8'h02, 3'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 3'd7, 4'd2, 8'h02, 3'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'd7, 4'd2, 8'h04, 3'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd7, 4'd2, 8'h00, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h01, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h02, 3'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h04, 3'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h08, 3'd3, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h10, 3'd4, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h20, 3'd5, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h40, 3'd6, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h80, 3'd7, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h01, 3'd0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 3'd0, 4'd0, 8'h02, 3'd1, 1'b0};

    reset_n = 1'b0; en = 1'b0; mode = 1'b0; x = 3'd0; dwell = 4'd0;
    model_reset();
    #12;
    check("rst.D", 32'(D), 32'h0);
    check("rst.idx", 32'(idx), 32'h0);
    check("rst.wrap", 32'(wrap), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle.D", 32'(D), 32'h0);
    end

    // Vector table
    for (int i = 0; i < 18; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; x = tbl[i].x; dwell = tbl[i].dwell;
      step();
      check($sformatf("tbl%0d.D", i), 32'(D), 32'(tbl[i].d));
      check($sformatf("tbl%0d.idx", i), 32'(idx), 32'(tbl[i].idx));
      check($sformatf("tbl%0d.wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Direct sweep: each x held 5 clocks, D follows one clock later
    mode = 1'b0; en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      x = 3'(v);
      for (int k = 0; k < 5; k++) begin
        step();
        check("sweep.D", 32'(D), 32'(1 << v));
        check("sweep.idx", 32'(idx), 32'(v));
      end
    end

    // Scan dwell=1: wraps 16 clocks after entry and 16 clocks apart
    en = 1'b0; step();
    en = 1'b1; mode = 1'b1; dwell = 4'd1;
    step();
    check("dw1.entry.D", 32'(D), 32'h01);
    check("dw1.entry.wrap", 32'(wrap), 32'h0);
    t_entry = 0; t_w1 = -1; t_w2 = -1;
    for (int c = 1; c <= 40 && t_w2 < 0; c++) begin
      step();
      if (wrap) begin
        if (t_w1 < 0) t_w1 = c; else t_w2 = c;
      end
    end
    check("dw1.first_wrap", 32'(t_w1 - t_entry), 32'd16);
    check("dw1.wrap_gap", 32'(t_w2 - t_w1), 32'd16);
    check("dw1.wrap.D", 32'(D), 32'h01);

    // Dwell lowered from 5 to 0 while prescaler sits at 3
    en = 1'b0; step();
    en = 1'b1; dwell = 4'd5; step();
    for (int k = 0; k < 3; k++) step();
    check("dwdrop.hold", 32'(idx), 32'd0);
    dwell = 4'd0; step();
    check("dwdrop.idx", 32'(idx), 32'd1);
    check("dwdrop.D", 32'(D), 32'h02);

    // Mode switch at idx=5, return to scan, drop en at idx=3
    n = 0;
    while (idx != 3'd5 && n < 64) begin step(); n++; end
    check("reach5.timeout", 32'(n < 64), 32'd1);
    mode = 1'b0; x = 3'd2; step();
    check("tod.D", 32'(D), 32'h04);
    mode = 1'b1; step();
    check("tos.D", 32'(D), 32'h01);
    check("tos.wrap", 32'(wrap), 32'h0);
    n = 0;
    while (idx != 3'd3 && n < 64) begin step(); n++; end
    check("reach3.timeout", 32'(n < 64), 32'd1);
    en = 1'b0; step();
    check("endrop.D", 32'(D), 32'h0);

    // Asynchronous reset mid-scan, no clock edge needed
    en = 1'b1; mode = 1'b1; dwell = 4'd0;
    for (int k = 0; k < 5; k++) step();
    #2;
    reset_n = 1'b0; en = 1'b0;
    model_reset();
    #1;
    check("arst.D", 32'(D), 32'h0);
    check("arst.idx", 32'(idx), 32'h0);
    check("arst.wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_rst.D", 32'(D), 32'h0);
    end

    // Random run against the model
    en = 1'b1; mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      x = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) dwell = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) dwell = 4'($urandom_range(0, 3));
      step();
      check_model("rnd");
      check_invariant();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
